// File: rtl/core_pkg.sv
// Shared types and constants for the BarelyFLOATing core front end.
package core_pkg;

   localparam int AW_DEFAULT = 6;
   localparam logic [15:0] HALT_WORD = 16'hE000;

   // Opcode field lives in word[15:11]; the halt word is OP_JMP with operand 0.
   localparam logic [4:0] OP_JMP = 5'b11100;

   typedef struct packed {
      logic [15:0]           word;
      logic [AW_DEFAULT-1:0] pc;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALTED
   } ifetch_state_t;

   function automatic logic [4:0] opcode_of(input logic [15:0] w);
      return w[15:11];
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries with a whole-queue flush.
module ifetch_fifo
   import core_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = fetch_entry_t
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  T                         din,
   output T                         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   T               mem_reg [DEPTH];
   logic [PW:0]    wr_ptr_reg;
   logic [PW:0]    rd_ptr_reg;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + CW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_reg[wr_ptr_reg[PW-1:0]] <= din;
   end

   assign count = wr_ptr_reg - rd_ptr_reg;
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (count == CW'(DEPTH));
   assign dout  = mem_reg[rd_ptr_reg[PW-1:0]];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: ROM -> prefetch FIFO -> decode handshake.
// Optional IFETCH_PERF_EN adds saturating stall/flush event counters.
module ifetch_unit #(
   parameter int          DEPTH     = 2,
   parameter int          AW        = core_pkg::AW_DEFAULT,
   parameter logic [15:0] HALT_WORD = core_pkg::HALT_WORD
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2**AW-1:0][15:0] mem,
   input  logic                   redirect_valid,
   input  logic [AW-1:0]          redirect_pc,
   output logic                   instr_valid,
   output logic [15:0]            instr,
   output logic [AW-1:0]          instr_pc,
   input  logic                   instr_ready,
`ifdef IFETCH_PERF_EN
   output logic [15:0]            stall_count,
   output logic [15:0]            flush_count,
`endif
   output logic                   halted
);

   import core_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [15:0]   word;
      logic [AW-1:0] pc;
   } entry_t;

   ifetch_state_t  state_reg, state_next;
   logic [AW-1:0]  pc_reg, pc_next;
   entry_t         head, tail;
   logic           full, empty;
   logic [CW-1:0]  count;
   logic           pop, fetch, redirect;
   logic [15:0]    fetch_word;

   assign fetch_word  = mem[pc_reg];
   assign instr_valid = !empty && (state_reg != HALTED);
   assign pop         = instr_valid && instr_ready;
   assign redirect    = redirect_valid && (state_reg != HALTED);
   // A full FIFO can still accept a word when the head leaves this cycle.
   assign fetch       = (state_reg == RUN) && !redirect && (!full || pop);
   assign tail        = '{word: fetch_word, pc: pc_reg};
   assign instr       = instr_valid ? head.word : '0;
   assign instr_pc    = instr_valid ? head.pc : '0;
   assign halted      = (state_reg == HALTED);

   ifetch_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect),
      .push  (fetch),
      .pop   (pop),
      .din   (tail),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
         pc_reg    <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      if (redirect) begin
         state_next = RUN;
         pc_next    = redirect_pc;
      end else begin
         // The halt word is queued but pc parks on its address.
         if (fetch) begin
            if (fetch_word == HALT_WORD) state_next = DRAIN;
            else                         pc_next    = pc_reg + AW'(1);
         end
         if ((state_reg == DRAIN) && pop && (head.word == HALT_WORD))
            state_next = HALTED;
      end
   end

`ifdef IFETCH_PERF_EN
   logic [15:0] stall_count_reg, flush_count_reg;
   logic        flush_drops;

   // A redirect that pops the last entry discards nothing.
   assign flush_drops = redirect && (count > CW'(pop));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_reg <= '0;
         flush_count_reg <= '0;
      end else begin
         if (instr_valid && !instr_ready && (stall_count_reg != 16'hFFFF))
            stall_count_reg <= stall_count_reg + 16'd1;
         if (flush_drops && (flush_count_reg != 16'hFFFF))
            flush_count_reg <= flush_count_reg + 16'd1;
      end
   end

   assign stall_count = stall_count_reg;
   assign flush_count = flush_count_reg;
`else
   logic unused_count;
   assign unused_count = ^count;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: queue-based reference model plus directed scenarios.
module tb_ifetch_unit;

   localparam int          AW    = 6;
   localparam int          DEPTH = 2;
   localparam int          NW    = 64;
   localparam logic [15:0] HALT  = 16'hE000;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NW-1:0][15:0]  mem;
   logic                 redirect_valid = 1'b0;
   logic [AW-1:0]        redirect_pc = '0;
   logic                 instr_ready = 1'b0;
   logic                 instr_valid;
   logic [15:0]          instr;
   logic [AW-1:0]        instr_pc;
   logic                 halted;
`ifdef IFETCH_PERF_EN
   logic [15:0]          stall_count;
   logic [15:0]          flush_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifetch_unit #(.DEPTH(DEPTH), .AW(AW), .HALT_WORD(HALT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem            (mem),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
`ifdef IFETCH_PERF_EN
      .stall_count    (stall_count),
      .flush_count    (flush_count),
`endif
      .halted         (halted)
   );

   // Reference model: a queue of (word, address) pairs plus two status flags.
   typedef struct {
      logic [15:0] w;
      int          pc;
   } ent_t;

   ent_t q[$];
   int   m_pc;
   bit   m_drain;
   bit   m_halted;

   function automatic bit m_valid();
      return (q.size() > 0) && !m_halted;
   endfunction

   task automatic model_reset();
      q.delete();
      m_pc     = 0;
      m_drain  = 0;
      m_halted = 0;
   endtask

   task automatic model_step();
      bit   pop;
      ent_t e;
      if (!rst_n) begin
         model_reset();
         return;
      end
      pop = m_valid() && instr_ready;
      if (m_halted) return;
      if (redirect_valid) begin
         q.delete();
         m_pc    = int'(redirect_pc);
         m_drain = 0;
         return;
      end
      if (pop) begin
         e = q.pop_front();
         if (e.w == HALT) m_halted = 1;
      end
      if (!m_drain && (q.size() < DEPTH)) begin
         e.w  = mem[m_pc];
         e.pc = m_pc;
         q.push_back(e);
         if (e.w == HALT) m_drain = 1;
         else             m_pc = (m_pc + 1) % NW;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of the DUT against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid", 32'(instr_valid), 32'(m_valid()));
         chk("halted", 32'(halted), 32'(m_halted));
         if (m_valid()) begin
            chk("instr", 32'(instr), 32'(q[0].w));
            chk("instr_pc", 32'(instr_pc), 32'(q[0].pc));
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      model_reset();
      #1;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_pc", 32'(instr_pc), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      cycle();
      cycle();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_linear();
      for (int i = 0; i < NW; i++) mem[i] = 16'h0100 + 16'(i);
   endtask

   // Advance until the model presents the word fetched from address a.
   task automatic run_until_head(input int a, output bit found);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_valid() && q[0].pc == a) found = 1;
         else cycle();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      load_linear();

      // Straight-line fetch with wrap from 63 to 0.
      instr_ready = 1'b1;
      do_reset();
      for (int n = 1; n <= 70; n++) begin
         cycle();
         if (n == 1) begin
            chk("first_valid", 32'(instr_valid), 32'd1);
            chk("first_instr", 32'(instr), 32'h0100);
            chk("first_pc", 32'(instr_pc), 32'd0);
         end
         if (n == 64) chk("pc63", 32'(instr_pc), 32'd63);
         if (n == 65) begin
            chk("wrap_pc", 32'(instr_pc), 32'd0);
            chk("wrap_instr", 32'(instr), 32'h0100);
         end
      end

      // Backpressure: head frozen for five cycles, then resumes in order.
      instr_ready = 1'b0;
      do_reset();
      cycle();
      for (int n = 0; n < 5; n++) begin
         cycle();
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_instr", 32'(instr), 32'h0100);
         chk("stall_pc", 32'(instr_pc), 32'd0);
      end
      instr_ready = 1'b1;
      cycle();
      chk("resume_pc1", 32'(instr_pc), 32'd1);
      cycle();
      chk("resume_pc2", 32'(instr_pc), 32'd2);
      cycle();
      chk("resume_pc3", 32'(instr_pc), 32'd3);

      // Redirect while the word at pc 7 is accepted.
      do_reset();
      run_until_head(7, found);
      chk("reach_pc7", 32'(found), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 6'd34;
      cycle();
      redirect_valid = 1'b0;
      chk("redir_bubble", 32'(instr_valid), 32'd0);
      cycle();
      chk("redir_valid", 32'(instr_valid), 32'd1);
      chk("redir_instr", 32'(instr), 32'h0122);
      chk("redir_pc", 32'(instr_pc), 32'd34);

      // Halt at address 5; later redirects are ignored.
      mem[5] = HALT;
      do_reset();
      run_until_head(5, found);
      chk("reach_halt", 32'(found), 32'd1);
      chk("halt_word", 32'(instr), 32'(HALT));
      cycle();
      chk("halted_set", 32'(halted), 32'd1);
      chk("halted_novalid", 32'(instr_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 6'd3;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      chk("halted_sticky", 32'(halted), 32'd1);
      chk("halted_ignore", 32'(instr_valid), 32'd0);

      // Redirect in the same cycle the halt word is popped wins.
      do_reset();
      run_until_head(5, found);
      chk("reach_halt2", 32'(found), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 6'd0;
      cycle();
      redirect_valid = 1'b0;
      chk("rvh_halted", 32'(halted), 32'd0);
      chk("rvh_bubble", 32'(instr_valid), 32'd0);
      cycle();
      chk("rvh_restart_pc", 32'(instr_pc), 32'd0);
      chk("rvh_restart_instr", 32'(instr), 32'h0100);

      // Asynchronous reset between edges with the FIFO full.
      load_linear();
      instr_ready = 1'b0;
      do_reset();
      cycle();
      cycle();
      cycle();
      chk("full_head", 32'(instr_pc), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(instr_valid), 32'd0);
      chk("async_instr", 32'(instr), 32'd0);
      chk("async_pc", 32'(instr_pc), 32'd0);
      model_reset();
      cycle();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      chk("post_async_pc", 32'(instr_pc), 32'd0);
      chk("post_async_instr", 32'(instr), 32'h0100);

      // Randomized segments against the model.
      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < NW; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? HALT : 16'($urandom);
         do_reset();
         for (int n = 0; n < 150; n++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = AW'($urandom);
            cycle();
         end
         redirect_valid = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end for the BarelyFLOATing core.
- Reads 16-bit instruction words from the packed 64-entry instruction ROM array, one word per cycle, into a small prefetch FIFO.
- Hands words to decode over a valid/ready handshake.
- Handles PC redirects from execute, and stops fetching when it fetches the halt word.

Parameters:
- DEPTH, 2, prefetch FIFO entries; legal values are powers of two, 2..8.
- AW, 6, PC/address width; ROM holds 2**AW words.
- HALT_WORD, 16'hE000, encoding that terminates fetch (opcode 11100, operand 0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem  in  [2**AW-1:0][15:0]  packed instruction ROM contents, combinational.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  AW  new fetch address.
- instr_valid  out  1  FIFO head valid toward decode.
- instr  out  16  FIFO head instruction word.
- instr_pc  out  AW  address the head word was fetched from.
- instr_ready  in  1  decode accepts the head word this cycle.
- halted  out  1  halt word has been consumed by decode.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=0, FIFO empty, state=RUN.
  - instr_valid=0, instr=0, instr_pc=0, halted=0.
- States:
  - RUN: fetching.
  - DRAIN: halt word is queued; no further fetches.
  - HALTED: halt word has been consumed.
- Fetch:
  - A fetch happens in RUN when the FIFO is not full, or is full and popping this cycle.
  - The fetch writes {mem[pc], pc} into the FIFO tail and sets pc=pc+1, modulo 2**AW (63 wraps to 0).
  - Latency: a word fetched in cycle N is visible on instr/instr_valid in cycle N+1.
  - First valid word appears in the first cycle after reset deassertion plus one edge.
- Halt:
  - When the fetched word equals HALT_WORD, it is enqueued normally and state goes RUN->DRAIN the same edge.
  - pc does not advance past the halt address.
- Pop: when instr_valid && instr_ready, the head is removed.
  - If the popped word is HALT_WORD, state goes DRAIN->HALTED and halted=1 next cycle.
  - The FIFO is empty in HALTED.
- HALTED: instr_valid=0 and halted=1 until reset. Redirects are ignored.
- Redirect (RUN or DRAIN):
  - Next edge: flush all FIFO entries, set pc=redirect_pc, state=RUN.
  - Flushed words are never presented to decode.
  - instr_valid is 0 the cycle after a redirect.
  - The word at redirect_pc appears one cycle later; redirect-to-valid latency is 2 cycles.
- Redirect in the same cycle as a pop: the pop completes (the head was the branch itself); the remainder is flushed.
- Redirect in the same cycle as a halt-word pop: the redirect has priority; state goes to RUN and halted stays 0.
- No fetch is performed in a redirect cycle.
- Full FIFO with no pop: fetch stalls and pc holds.
- instr and instr_pc hold their value while instr_valid && !instr_ready; they never change mid-stall.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Adds output stall_count [15:0] and output flush_count [15:0].
  - Both reset to 0 and saturate at 16'hFFFF.
  - stall_count increments each cycle with instr_valid && !instr_ready.
  - flush_count increments once per redirect that discards at least one valid FIFO entry.
- Undefined: neither port nor counter exists. Functional behaviour is identical.

Decomposition:
- Package core_pkg:
  - AW default.
  - HALT_WORD constant.
  - opcode field constants (OP_JMP=5'b11100).
  - typedef fetch_entry_t = struct {logic [15:0] word; logic [AW-1:0] pc}.
  - enum ifetch_state_t {RUN, DRAIN, HALTED}.
- Sub-module ifetch_fifo: generic DEPTH-entry synchronous FIFO of fetch_entry_t with flush input, push/pop, and full/empty outputs.
- The top holds the pc, the state machine and the handshake.

Test Plan:
- Straight-line fetch: mem[i]=i+16'h100 with no halt word, instr_ready=1 after reset → words 0x0100, 0x0101, … on consecutive cycles; instr_pc wraps 63→0.
- Backpressure: instr_ready=0 for 5 cycles → instr_valid=1, instr/instr_pc frozen, pc stops after DEPTH fetches; on release, the sequence resumes with no gaps or duplicates.
- Redirect: in the cycle word at pc 7 is accepted, assert redirect_pc=34 → next cycle instr_valid=0, following cycle instr=mem[34], instr_pc=34; words from pc 8/9 are never output.
- Halt: mem[5]=16'hE000 → words 0..5 delivered; pc holds at 5; halted=1 one cycle after word 5 is accepted; instr_valid stays 0; a later redirect_valid has no effect.
- Redirect vs halt pop: redirect_valid=1 with redirect_pc=0 in the cycle the halt word is popped → halted stays 0 and fetch restarts at 0.
- Async reset mid-stream: drop rst_n between clock edges while the FIFO is full → outputs go to reset values immediately; after release, fetch restarts from pc 0.
